// File: rtl/axi_llc_sram_data_banked.sv
// Word-interleaved, multi-bank LLC data array. Each bank has its own round-robin
// arbiter, and read data returns a fixed Latency cycles after the grant.
module axi_llc_sram_data_banked #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  parameter int unsigned CntWidth  = 16,
  parameter string       SimInit   = "none",
  parameter int unsigned AddrWidth = $clog2(NumWords),
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumPorts-1:0]                req_i,
  output logic [NumPorts-1:0]                gnt_o,
  input  logic [NumPorts-1:0]                we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]   be_i,
  output logic [NumPorts-1:0]                rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0] rdata_o,
  input  logic                               cnt_clr_i,
  output logic [CntWidth-1:0]                conflict_cnt_o
);

  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned BankIdxW = (NumBanks > 1) ? BankBits : 1;
  localparam int unsigned RowWidth = AddrWidth - BankBits;
  localparam int unsigned Rows     = NumWords / NumBanks;
  localparam int unsigned PortIdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  if ((NumWords % NumBanks) != 0) begin : g_err_words
    $error("NumWords must be a multiple of NumBanks");
  end
  if (SimInit != "none" && SimInit != "zeros" && SimInit != "ones" && SimInit != "random") begin : g_err_init
    $error("SimInit must be none, zeros, ones or random");
  end

  logic [NumPorts-1:0][BankIdxW-1:0] port_bank;
  logic [NumPorts-1:0][RowWidth-1:0] port_row;

  for (genvar p = 0; p < NumPorts; p++) begin : g_map
    if (NumBanks > 1) begin : g_multi
      assign port_bank[p] = addr_i[p][BankBits-1:0];
      assign port_row[p]  = addr_i[p][AddrWidth-1:BankBits];
    end else begin : g_single
      assign port_bank[p] = '0;
      assign port_row[p]  = addr_i[p];
    end
  end

  logic [NumBanks-1:0]                bank_gnt;
  logic [NumBanks-1:0][PortIdxW-1:0]  bank_win;
  logic [NumBanks-1:0][PortIdxW-1:0]  rr_ptr;
  logic [NumBanks-1:0]                bank_we;
  logic [NumBanks-1:0][RowWidth-1:0]  bank_row;
  logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
  logic [NumBanks-1:0][BeWidth-1:0]   bank_be;
  logic [NumBanks-1:0][DataWidth-1:0] bank_rdata;

  // Offset i walks the ports starting at the bank's pointer; first requester found wins.
  always_comb begin
    gnt_o      = '0;
    bank_gnt   = '0;
    bank_win   = '0;
    bank_we    = '0;
    bank_row   = '0;
    bank_wdata = '0;
    bank_be    = '0;
    for (int b = 0; b < int'(NumBanks); b++) begin
      for (int i = 0; i < int'(NumPorts); i++) begin
        for (int p = 0; p < int'(NumPorts); p++) begin
          if (!bank_gnt[b] && req_i[p] && (int'(port_bank[p]) == b) &&
              ((int'(rr_ptr[b]) + i == p) || (int'(rr_ptr[b]) + i == p + int'(NumPorts)))) begin
            bank_gnt[b]   = 1'b1;
            bank_win[b]   = PortIdxW'(p);
            gnt_o[p]      = 1'b1;
            bank_we[b]    = we_i[p];
            bank_row[b]   = port_row[p];
            bank_wdata[b] = wdata_i[p];
            bank_be[b]    = be_i[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else begin
      for (int b = 0; b < int'(NumBanks); b++) begin
        if (bank_gnt[b]) begin
          rr_ptr[b] <= (int'(bank_win[b]) == int'(NumPorts) - 1) ? '0 : bank_win[b] + 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [DataWidth-1:0]              mem [Rows];
    logic [DataWidth-1:0]              wmask;
    logic [Latency-1:0][DataWidth-1:0] rd_pipe;

    for (genvar j = 0; j < DataWidth; j++) begin : g_mask
      assign wmask[j] = bank_be[b][j / ByteWidth];
    end

    // Storage is intentionally not reset; only the read path is flushed.
    always_ff @(posedge clk_i) begin
      if (bank_gnt[b] && bank_we[b]) begin
        mem[bank_row[b]] <= (mem[bank_row[b]] & ~wmask) | (bank_wdata[b] & wmask);
      end
      if (bank_gnt[b] && !bank_we[b]) begin
        rd_pipe[0] <= mem[bank_row[b]];
      end
      for (int s = 1; s < int'(Latency); s++) begin
        rd_pipe[s] <= rd_pipe[s-1];
      end
    end

    assign bank_rdata[b] = rd_pipe[Latency-1];
  end

  logic [Latency-1:0][NumPorts-1:0]               trk_v;
  logic [Latency-1:0][NumPorts-1:0][BankIdxW-1:0] trk_bank;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_v    <= '0;
      trk_bank <= '0;
    end else begin
      trk_v[0]    <= gnt_o & req_i & ~we_i;
      trk_bank[0] <= port_bank;
      for (int s = 1; s < int'(Latency); s++) begin
        trk_v[s]    <= trk_v[s-1];
        trk_bank[s] <= trk_bank[s-1];
      end
    end
  end

  assign rvalid_o = trk_v[Latency-1];

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      if (rvalid_o[p]) begin
        rdata_o[p] = bank_rdata[trk_bank[Latency-1][p]];
      end
    end
  end

  logic conflict;
  assign conflict = |(req_i & ~gnt_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != {CntWidth{1'b1}})) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_llc_sram_data_banked.sv
// Directed bench for the banked LLC data array: a vector table for the single-cycle
// behaviour plus sequences for reset flush and counter saturation/clear.
module tb_axi_llc_sram_data_banked;

  localparam int DW = 128;
  localparam int AW = 10;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]         req, we;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic [1:0][BW-1:0] be;
  logic               cnt_clr;

  logic [1:0]         gnt, rvalid;
  logic [1:0][DW-1:0] rdata;
  logic [15:0]        cnt;
  logic [1:0]         gnt_l2, rvalid_l2;
  logic [1:0][DW-1:0] rdata_l2;
  logic [15:0]        cnt_l2;
  logic [1:0]         gnt_c2, rvalid_c2;
  logic [1:0][DW-1:0] rdata_c2;
  logic [1:0]         cnt_c2;

  axi_llc_sram_data_banked u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata),
    .cnt_clr_i(cnt_clr), .conflict_cnt_o(cnt)
  );

  axi_llc_sram_data_banked #(.Latency(2)) u_lat2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_l2), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_l2), .rdata_o(rdata_l2),
    .cnt_clr_i(cnt_clr), .conflict_cnt_o(cnt_l2)
  );

  axi_llc_sram_data_banked #(.CntWidth(2)) u_cnt2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_c2), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid_c2), .rdata_o(rdata_c2),
    .cnt_clr_i(cnt_clr), .conflict_cnt_o(cnt_c2)
  );

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [BW-1:0] be0, be1;
    logic [1:0]    exp_gnt;
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_r0, exp_r1;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t tv[14];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req = '0; we = '0; addr = '0; wdata = '0; be = '0; cnt_clr = 1'b0;
  endtask

  function automatic vec_t mk(logic [1:0] rq, logic [1:0] w, int a0, int a1,
                              logic [DW-1:0] d0, logic [DW-1:0] d1,
                              logic [BW-1:0] b0, logic [BW-1:0] b1,
                              logic [1:0] g, logic [1:0] rv,
                              logic [DW-1:0] r0, logic [DW-1:0] r1, int c);
    vec_t v;
    v.req = rq; v.we = w; v.a0 = AW'(a0); v.a1 = AW'(a1);
    v.d0 = d0; v.d1 = d1; v.be0 = b0; v.be1 = b1;
    v.exp_gnt = g; v.exp_rv = rv; v.exp_r0 = r0; v.exp_r1 = r1; v.exp_cnt = 16'(c);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a5, d1, d6, c0, c3, ones, z, lo_ff, d6_top0;
    logic [BW-1:0] all_be;
    a5 = {16{8'hA5}}; d1 = {16{8'h11}}; d6 = {16{8'h66}};
    c0 = {16{8'hC0}}; c3 = {16{8'hC3}}; ones = {DW{1'b1}}; z = '0;
    lo_ff = 128'hFF; d6_top0 = {8'h00, {15{8'h66}}}; all_be = '1;

    //             req    we     a0 a1 d0    d1  be0     be1      gnt    rv     r0     r1       cnt
    tv[0]  = mk(2'b01, 2'b01, 5, 0, a5,   z,  all_be, '0,      2'b01, 2'b00, z,     z,       0);
    tv[1]  = mk(2'b10, 2'b00, 0, 5, z,    z,  '0,     '0,      2'b10, 2'b10, z,     a5,      0);
    tv[2]  = mk(2'b11, 2'b11, 6, 1, d6,   d1, all_be, all_be,  2'b11, 2'b00, z,     z,       0);
    tv[3]  = mk(2'b11, 2'b00, 1, 5, z,    z,  '0,     '0,      2'b01, 2'b01, d1,    z,       1);
    tv[4]  = mk(2'b11, 2'b00, 1, 5, z,    z,  '0,     '0,      2'b10, 2'b10, z,     a5,      2);
    tv[5]  = mk(2'b11, 2'b00, 1, 5, z,    z,  '0,     '0,      2'b01, 2'b01, d1,    z,       3);
    tv[6]  = mk(2'b11, 2'b00, 1, 5, z,    z,  '0,     '0,      2'b10, 2'b10, z,     a5,      4);
    tv[7]  = mk(2'b11, 2'b11, 0, 3, c0,   c3, all_be, all_be,  2'b11, 2'b00, z,     z,       4);
    tv[8]  = mk(2'b11, 2'b00, 0, 3, z,    z,  '0,     '0,      2'b11, 2'b11, c0,    c3,      4);
    tv[9]  = mk(2'b01, 2'b01, 8, 0, z,    z,  all_be, '0,      2'b01, 2'b00, z,     z,       4);
    tv[10] = mk(2'b01, 2'b01, 8, 0, ones, z,  16'h0001, '0,    2'b01, 2'b00, z,     z,       4);
    tv[11] = mk(2'b11, 2'b00, 8, 6, z,    z,  '0,     '0,      2'b11, 2'b11, lo_ff, d6,      4);
    tv[12] = mk(2'b10, 2'b10, 0, 6, z,    z,  '0,     16'h8000, 2'b10, 2'b00, z,    z,       4);
    tv[13] = mk(2'b10, 2'b00, 0, 6, z,    z,  '0,     '0,      2'b10, 2'b10, z,     d6_top0, 4);

    // Reset values
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rvalid", DW'(rvalid), DW'(2'b00));
    check("reset_rdata0", rdata[0], z);
    check("reset_rdata1", rdata[1], z);
    check("reset_cnt", DW'(cnt), z);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency=2 read killed by a mid-flight reset must never signal rvalid
    @(negedge clk);
    req = 2'b01; addr[0] = AW'(2);
    #1;
    check("rst_flush_gnt", DW'(gnt_l2), DW'(2'b01));
    @(posedge clk);
    #1;
    check("rst_flush_l2_stage1", DW'(rvalid_l2), DW'(2'b00));
    drive_idle();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_flush_main_async", DW'(rvalid), DW'(2'b00));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_flush_l2_in_reset", DW'(rvalid_l2), DW'(2'b00));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_flush_l2_after", DW'(rvalid_l2), DW'(2'b00));
    end

    // Vector table
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      req = tv[k].req; we = tv[k].we;
      addr[0] = tv[k].a0; addr[1] = tv[k].a1;
      wdata[0] = tv[k].d0; wdata[1] = tv[k].d1;
      be[0] = tv[k].be0; be[1] = tv[k].be1;
      #1;
      check($sformatf("v%0d_gnt", k), DW'(gnt), DW'(tv[k].exp_gnt));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rvalid", k), DW'(rvalid), DW'(tv[k].exp_rv));
      check($sformatf("v%0d_rdata0", k), rdata[0], tv[k].exp_r0);
      check($sformatf("v%0d_rdata1", k), rdata[1], tv[k].exp_r1);
      check($sformatf("v%0d_cnt", k), DW'(cnt), DW'(tv[k].exp_cnt));
    end

    // Counter clear, then saturation of the 2-bit counter
    @(negedge clk);
    drive_idle();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_idle_main", DW'(cnt), z);
    check("clr_idle_c2", DW'(cnt_c2), z);
    @(negedge clk);
    cnt_clr = 1'b0;
    req = 2'b11; addr[0] = AW'(1); addr[1] = AW'(5);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat_c2_%0d", i), DW'(cnt_c2), DW'((i > 3) ? 3 : i));
      check($sformatf("sat_main_%0d", i), DW'(cnt), DW'(i));
    end
    @(negedge clk);
    cnt_clr = 1'b1;
    #1;
    check("clr_conflict_present", DW'(|(req & ~gnt)), DW'(1'b1));
    @(posedge clk);
    #1;
    check("clr_conflict_c2", DW'(cnt_c2), z);
    check("clr_conflict_main", DW'(cnt), z);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("idle_after_clr", DW'(cnt), z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
